// File: rtl/fp_norm_round64_if.sv
// Data and qualifier bundle for the double-precision normalize/round stage.
interface fp_norm_round64_if;
  logic [2:0]   rm;
  logic         i_valid;
  logic         i_sign;
  logic [10:0]  i_exp;
  logic [107:0] i_sig;
  logic         o_valid;
  logic [63:0]  o;
  logic         o_nx;
  logic         o_of;
  logic         o_uf;

  modport master (
    output rm, i_valid, i_sign, i_exp, i_sig,
    input  o_valid, o, o_nx, o_of, o_uf
  );

  modport slave (
    input  rm, i_valid, i_sign, i_exp, i_sig,
    output o_valid, o, o_nx, o_of, o_uf
  );
endinterface

// File: rtl/fp_norm_round64.sv
// Four-stage normalize + round for adder results, producing an IEEE double.
// S1: capture + leading-zero count, S2: normalize, S3: round/pack, S4: output.
module fp_norm_round64 (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  fp_norm_round64_if.slave bus
);
  localparam int EMSB = 10;
  localparam int FMSB = 51;
  localparam int FX   = 107;

  // ---------------- stage 1 ----------------
  logic            s1_sign, s1_spec, s1_zero;
  logic [EMSB:0]   s1_exp;
  logic [FX:0]     s1_sig;
  logic [2:0]      s1_rm;
  logic [6:0]      s1_lz, lz_c;

  // Leading-zero count; the highest set bit wins, all-zero gives 108.
  always_comb begin
    lz_c = 7'd108;
    for (int i = 0; i <= FX; i++)
      if (bus.i_sig[i]) lz_c = 7'(FX - i);
  end

  // Capture inputs and classify them.
  always_ff @(posedge clk) begin
    if (ce) begin
      s1_sign <= bus.i_sign;
      s1_exp  <= bus.i_exp;
      s1_sig  <= bus.i_sig;
      s1_rm   <= bus.rm;
      s1_spec <= (bus.i_exp == 11'h7FF);
      s1_zero <= (bus.i_sig == '0) && (bus.i_exp != 11'h7FF);
      s1_lz   <= lz_c;
    end
  end

  // ---------------- stage 2 ----------------
  logic [11:0]     lim_c, lzm1_c, e_c;
  logic [6:0]      s_c;
  logic [FX-1:0]   n_c;
  logic            stk_c, den_c;

  logic            s2_sign, s2_spec, s2_zero, s2_stk, s2_den;
  logic [11:0]     s2_e;
  logic [FX-1:0]   s2_n;
  logic [2:0]      s2_rm;
  logic [FMSB:0]   s2_sfrac;

  // Normalize: a carry shifts right once; otherwise shift left until the
  // hidden bit is set, but never past exponent 1 (that leaves a denormal).
  always_comb begin
    stk_c  = 1'b0;
    s_c    = '0;
    lim_c  = (s1_exp == '0) ? 12'd0 : {1'b0, s1_exp} - 12'd1;
    lzm1_c = {5'b0, s1_lz} - 12'd1;
    n_c    = s1_sig[FX-1:0];
    e_c    = {1'b0, s1_exp};
    if (s1_sig[FX]) begin
      n_c   = s1_sig[FX:1];
      e_c   = {1'b0, s1_exp} + 12'd1;
      stk_c = s1_sig[0];
    end else begin
      s_c = (lzm1_c < lim_c) ? lzm1_c[6:0] : lim_c[6:0];
      n_c = FX'(s1_sig << s_c);
      e_c = {1'b0, s1_exp} - {5'b0, s_c};
    end
    den_c = ~n_c[FX-1] & ~s1_zero;
  end

  // Register the normalized significand; denormals get exponent field 0.
  always_ff @(posedge clk) begin
    if (ce) begin
      s2_sign  <= s1_sign;
      s2_spec  <= s1_spec;
      s2_zero  <= s1_zero;
      s2_rm    <= s1_rm;
      s2_n     <= n_c;
      s2_stk   <= stk_c;
      s2_den   <= den_c;
      s2_e     <= den_c ? 12'd0 : e_c;
      s2_sfrac <= s1_sig[105:54];
    end
  end

  // ---------------- stage 3 ----------------
  logic [FMSB:0]   f_c;
  logic            g_c, r_c, st_c, grs_c, inc_c, ovf_c, inf_c;
  logic [FMSB+1:0] sum_c;
  logic [11:0]     er_c;
  logic [63:0]     res_c;
  logic            nx_c, of_c, uf_c;

  logic [63:0]     s3_o;
  logic            s3_nx, s3_of, s3_uf;

  // Round by mode, propagate any carry into the exponent, then pick the
  // final encoding (special / zero / overflow / ordinary).
  always_comb begin
    f_c   = s2_n[105:54];
    g_c   = s2_n[53];
    r_c   = s2_n[52];
    st_c  = (|s2_n[51:0]) | s2_stk;
    grs_c = g_c | r_c | st_c;
    case (s2_rm)
      3'd1:    inc_c = 1'b0;
      3'd2:    inc_c = ~s2_sign & grs_c;
      3'd3:    inc_c = s2_sign & grs_c;
      3'd4:    inc_c = g_c;
      default: inc_c = g_c & (r_c | st_c | f_c[0]);
    endcase
    sum_c = {1'b0, f_c} + {{(FMSB+1){1'b0}}, inc_c};
    // A denormal carrying into the hidden bit goes from field 0 to 1.
    er_c  = s2_e + {11'b0, sum_c[FMSB+1]};
    ovf_c = (er_c >= 12'h7FF);
    case (s2_rm)
      3'd1:    inf_c = 1'b0;
      3'd2:    inf_c = ~s2_sign;
      3'd3:    inf_c = s2_sign;
      default: inf_c = 1'b1;
    endcase
    res_c = {s2_sign, er_c[EMSB:0], sum_c[FMSB:0]};
    nx_c  = grs_c;
    of_c  = 1'b0;
    uf_c  = s2_den & grs_c;
    if (s2_spec) begin
      res_c = {s2_sign, 11'h7FF, s2_sfrac};
      nx_c  = 1'b0;
      uf_c  = 1'b0;
    end else if (s2_zero) begin
      res_c = {s2_sign, 63'd0};
      nx_c  = 1'b0;
      uf_c  = 1'b0;
    end else if (ovf_c) begin
      res_c = inf_c ? {s2_sign, 11'h7FF, 52'd0} : {s2_sign, 11'h7FE, {52{1'b1}}};
      nx_c  = 1'b1;
      of_c  = 1'b1;
      uf_c  = 1'b0;
    end
  end

  // Register the packed result.
  always_ff @(posedge clk) begin
    if (ce) begin
      s3_o  <= res_c;
      s3_nx <= nx_c;
      s3_of <= of_c;
      s3_uf <= uf_c;
    end
  end

  // ---------------- stage 4 / valid pipe ----------------
  logic [4:1]  vld_pipe;
  logic [63:0] o_q;
  logic        nx_q, of_q, uf_q;

  // Valid shift register; reset wins over ce so in-flight data is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n)  vld_pipe <= '0;
    else if (ce) vld_pipe <= {vld_pipe[3:1], bus.i_valid};
  end

  // Output register, cleared by reset regardless of ce.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q  <= '0;
      nx_q <= 1'b0;
      of_q <= 1'b0;
      uf_q <= 1'b0;
    end else if (ce) begin
      o_q  <= s3_o;
      nx_q <= s3_nx;
      of_q <= s3_of;
      uf_q <= s3_uf;
    end
  end

  assign bus.o_valid = vld_pipe[4];
  assign bus.o       = o_q;
  assign bus.o_nx    = nx_q;
  assign bus.o_of    = of_q;
  assign bus.o_uf    = uf_q;
endmodule

// File: doc/fp_norm_round64.md
FP_NORM_ROUND64 -- requirements
Module: fp_norm_round64

Interface
REQ-001 The block SHALL have the parameters: none; double-precision only, with EMSB=10, FMSB=51 and FX=107 fixed.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- ce  in  1  clock enable; when low, all pipeline registers hold.
- rm  in  3  rounding mode, sampled with the data: 0 RNE, 1 RTZ, 2 RUP, 3 RDN, 4 RMM; 5-7 are treated as RNE.
- i_valid  in  1  input qualifier.
- i_sign  in  1  sign from the adder output.
- i_exp  in  11  biased exponent from the adder.
- i_sig  in  108  extended significand from the adder.
- o_valid  out  1  result qualifier.
- o  out  64  IEEE-754 double result.
- o_nx  out  1  inexact flag.
- o_of  out  1  overflow flag.
- o_uf  out  1  underflow flag.

Function
REQ-003 Input value SHALL be (-1)^i_sign * (i_sig / 2^106) * 2^(i_exp-1023); i_sig[107] is the carry bit and i_sig[106] is the hidden-bit position; a denormal arrives with i_exp=1.
REQ-004 Latency SHALL be exactly 4 ce-qualified cycles; i_valid propagates to o_valid through a 4-deep valid pipe; the block accepts one input per ce cycle, with no back-pressure.
REQ-005 Stage 1 SHALL register the inputs and rm, flag special inputs (i_exp=0x7FF), flag zero inputs (i_sig=0 and not special), and compute lz = leading-zero count of i_sig (0..108).
REQ-006 Stage 2 SHALL normalize as follows:
- If sig[107]=1: shift right 1; e=exp+1; the shifted-out bit ORs into sticky.
- Otherwise: shift left by s=min(lz-1, exp-1); e=exp-s.
- Exponent arithmetic SHALL be 12-bit, so underflow never wraps.
REQ-007 After normalization, if hidden bit n[106]=0 and the result is not zero, the exponent field SHALL be 0 (denormal), with the fraction taken unshifted.
REQ-008 Stage 3 SHALL round using these fields:
- Fraction f=n[105:54]; G=n[53]; R=n[52]; S=|n[51:0] | sticky.
- Increment when: RNE on G&(R|S|f[0]); RMM on G; RUP on ~sign&(G|R|S); RDN on sign&(G|R|S); RTZ never.
REQ-009 A rounding carry out of f SHALL increment the exponent; a carry from a denormal into the hidden bit SHALL set the exponent field to 1.
REQ-010 On overflow (exponent >= 0x7FF after rounding, on a non-special input), the result SHALL be:
- Infinity for RNE and RMM, for RUP with positive sign, and for RDN with negative sign.
- Otherwise 0x7FE with an all-ones fraction.
- o_of=1 and o_nx=1 in every overflow case.
REQ-011 Special inputs SHALL pass through as {sign, 0x7FF, i_sig[105:54]} with no rounding and all flags 0.
REQ-012 Zero inputs SHALL produce {sign, 0, 0} with flags 0; the sign passes through unchanged.
REQ-013 Flags SHALL be: o_nx = G|R|S, or overflow; o_uf = the pre-round result is denormal and o_nx=1.
REQ-014 Stage 4 SHALL register o, the flags and o_valid; o and the flags are meaningful only when o_valid=1.
REQ-015 With ce=0, outputs and all internal state SHALL hold, including o_valid.

Reset
REQ-016 When rst_n=0 at a clock edge, the block SHALL:
- Clear all valid-pipe bits, o_valid, o and the flags to 0, regardless of ce.
- Drop in-flight data; no output appears for inputs accepted before reset.
REQ-017 The first input accepted after rst_n rises SHALL emerge 4 ce cycles later; no spurious o_valid SHALL occur before then.

Verification
REQ-018 The bench SHALL cover at least these directed scenarios:
- Carry: sign 0, exp 0x3FF, i_sig[107]=1, rest 0, rm=0 -> o=0x4000000000000000 after 4 cycles, flags 0.
- Cancellation: exp 0x3FF, only i_sig[54]=1 -> o=0x3CB0000000000000, flags 0.
- Tie: exp 0x3FF, i_sig[106]=i_sig[54]=i_sig[53]=1 -> RNE gives 0x3FF0000000000002 with nx=1; RTZ gives 0x3FF0000000000001 with nx=1.
- Overflow: exp 0x7FE, i_sig[107]=1, i_sig[106]=1 -> rm=0 gives 0x7FF0000000000000, of=nx=1; rm=1 gives 0x7FEFFFFFFFFFFFFF.
- Denormal: exp 1, only i_sig[105]=1 -> o=0x0008000000000000, uf=0; adding i_sig[0]=1 gives nx=uf=1.
- Reset and enable: apply valid inputs for 3 cycles, then rst_n=0 for 1 cycle -> o_valid stays 0 throughout. Stall with ce=0 for 5 cycles mid-stream -> outputs hold, and ordering and latency resume intact.
